// File: rtl/mem_stage.sv
// Memory-access stage: waits for the data-SRAM response of a request issued in execute,
// extracts/extends load data, builds lwl/lwr byte strobes and forwards CP0/TLB status upstream.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 135,
  parameter int MS_TO_WS_BUS_WD = 126
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       flush,
  output logic [31:0]                ms_forward_data,
  output logic                       ms_load_wait,
  output logic                       ms_ex,
  output logic                       ms_eret,
  output logic                       ms_mtc0,
  output logic                       ms_tlb_reflush,
  output logic                       out_ms_valid
);

  logic                       ms_valid_q, ms_valid_d;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;
  logic                       buf_valid_q, buf_valid_d;
  logic [31:0]                rdata_buf_q, rdata_buf_d;
  logic                       discard_q, discard_d;

  logic        tlb_refill, tlbwi, tlbr, store, lw;
  logic [31:0] badvaddr;
  logic        bd;
  logic [7:0]  c0_addr;
  logic        ex, eret, mtc0, mfc0;
  logic [4:0]  excode;
  logic        lb, lbu, lh, lhu, lwl, lwr, res_from_mem;
  logic [3:0]  gr_we;
  logic [4:0]  dest;
  logic [31:0] result, pc;

  assign {tlb_refill, tlbwi, tlbr, store, lw, badvaddr, bd, c0_addr, ex, excode,
          eret, mtc0, mfc0, lb, lbu, lh, lhu, lwl, lwr, res_from_mem,
          gr_we, dest, result, pc} = bus_q;

  logic        mem_op, data_ok_eff, ms_ready_go;
  logic [31:0] rdata_eff, load_data, final_result;
  logic [3:0]  ld_we, gr_we_out;
  logic [1:0]  a;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // A response tagged for discard belongs to a flushed request and never counts.
  assign mem_op       = (res_from_mem || store) && !ex;
  assign data_ok_eff  = data_sram_data_ok && !discard_q;
  assign ms_ready_go  = !mem_op || buf_valid_q || data_ok_eff;
  assign ms_allowin   = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign rdata_eff    = buf_valid_q ? rdata_buf_q : data_sram_rdata;
  assign a            = result[1:0];

  always_comb begin
    ms_valid_d  = ms_valid_q;
    bus_d       = bus_q;
    buf_valid_d = buf_valid_q;
    rdata_buf_d = rdata_buf_q;
    discard_d   = discard_q;
    if (flush)
      ms_valid_d = 1'b0;
    else if (ms_allowin)
      ms_valid_d = es_to_ms_valid;
    if (es_to_ms_valid && ms_allowin)
      bus_d = es_to_ms_bus;
    if (flush || (ms_to_ws_valid && ws_allowin)) begin
      buf_valid_d = 1'b0;
    end else if (ms_valid_q && mem_op && !buf_valid_q && !ws_allowin && data_ok_eff) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end
    if (data_sram_data_ok && discard_q)
      discard_d = 1'b0;
    if (flush && ms_valid_q && mem_op && !buf_valid_q && !data_sram_data_ok)
      discard_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q  <= 1'b0;
      bus_q       <= '0;
      buf_valid_q <= 1'b0;
      rdata_buf_q <= 32'h0;
      discard_q   <= 1'b0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      bus_q       <= bus_d;
      buf_valid_q <= buf_valid_d;
      rdata_buf_q <= rdata_buf_d;
      discard_q   <= discard_d;
    end
  end

  always_comb begin
    case (a)
      2'd0:    byte_sel = rdata_eff[7:0];
      2'd1:    byte_sel = rdata_eff[15:8];
      2'd2:    byte_sel = rdata_eff[23:16];
      default: byte_sel = rdata_eff[31:24];
    endcase
    half_sel  = a[1] ? rdata_eff[31:16] : rdata_eff[15:0];
    load_data = rdata_eff;
    ld_we     = gr_we;
    if (lw) begin
      load_data = rdata_eff;
    end else if (lb) begin
      load_data = {{24{byte_sel[7]}}, byte_sel};
    end else if (lbu) begin
      load_data = {24'h0, byte_sel};
    end else if (lh) begin
      load_data = {{16{half_sel[15]}}, half_sel};
    end else if (lhu) begin
      load_data = {16'h0, half_sel};
    end else if (lwl) begin
      case (a)
        2'd0:    begin load_data = rdata_eff << 24; ld_we = 4'b1000; end
        2'd1:    begin load_data = rdata_eff << 16; ld_we = 4'b1100; end
        2'd2:    begin load_data = rdata_eff << 8;  ld_we = 4'b1110; end
        default: begin load_data = rdata_eff;       ld_we = 4'b1111; end
      endcase
    end else if (lwr) begin
      case (a)
        2'd0:    begin load_data = rdata_eff;       ld_we = 4'b1111; end
        2'd1:    begin load_data = rdata_eff >> 8;  ld_we = 4'b0111; end
        2'd2:    begin load_data = rdata_eff >> 16; ld_we = 4'b0011; end
        default: begin load_data = rdata_eff >> 24; ld_we = 4'b0001; end
      endcase
    end
  end

  assign final_result = res_from_mem ? load_data : result;
  assign gr_we_out    = ex ? 4'b0000 : ld_we;

  assign ms_to_ws_bus = {tlb_refill, tlbwi, tlbr, badvaddr, bd, c0_addr, ex, excode,
                         eret, mtc0, mfc0, gr_we_out, dest, final_result, pc};

  assign ms_forward_data = final_result;
  assign ms_load_wait    = ms_valid_q && res_from_mem && !ms_ready_go;
  assign ms_ex           = ms_valid_q && ex;
  assign ms_eret         = ms_valid_q && eret;
  assign ms_mtc0         = ms_valid_q && mtc0;
  assign ms_tlb_reflush  = ms_valid_q && (tlbwi || tlbr);
  assign out_ms_valid    = ms_valid_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single instructions plus hand-written
// sequences for buffered responses, flush/discard and flush-vs-entry.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [134:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [125:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         flush;
  logic [31:0]  ms_forward_data;
  logic         ms_load_wait, ms_ex, ms_eret, ms_mtc0, ms_tlb_reflush, out_ms_valid;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .flush(flush), .ms_forward_data(ms_forward_data), .ms_load_wait(ms_load_wait),
    .ms_ex(ms_ex), .ms_eret(ms_eret), .ms_mtc0(ms_mtc0),
    .ms_tlb_reflush(ms_tlb_reflush), .out_ms_valid(out_ms_valid)
  );

  always #5 clk = ~clk;

  wire [31:0] o_res    = ms_to_ws_bus[63:32];
  wire [3:0]  o_gwe    = ms_to_ws_bus[72:69];
  wire [4:0]  o_excode = ms_to_ws_bus[80:76];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // ld = {lw, lb, lbu, lh, lhu, lwl, lwr}
  function automatic logic [134:0] make_bus(input logic [6:0] ld, input logic rfm,
      input logic st, input logic ex, input logic [4:0] excode,
      input logic [3:0] gwe, input logic [31:0] res);
    logic [134:0] b;
    b = '0;
    b[131]    = st;
    b[130]    = ld[6];
    b[88]     = ex;
    b[87:83]  = excode;
    b[79:74]  = ld[5:0];
    b[73]     = rfm;
    b[72:69]  = gwe;
    b[68:64]  = 5'd8;
    b[63:32]  = res;
    b[31:0]   = 32'hBFC0_0100;
    return b;
  endfunction

  typedef struct {
    string       nm;
    logic [6:0]  ld;
    logic        rfm;
    logic        st;
    logic        ex;
    logic [4:0]  excode;
    logic [3:0]  gwe;
    logic [31:0] res;
    logic [31:0] rdata;
    logic [31:0] exp_res;
    logic [3:0]  exp_gwe;
  } vec_t;

  vec_t vecs[12];

  task automatic issue_lw(input logic [31:0] addr);
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = make_bus(7'b1000000, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, addr);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"addu", 7'b0000000, 1'b0, 1'b0, 1'b0, 5'd0, 4'hF, 32'h0000_1234, 32'h0, 32'h0000_1234, 4'hF};
    vecs[1]  = '{"lb",   7'b0100000, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80, 4'hF};
    vecs[2]  = '{"lbu",  7'b0010000, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080, 4'hF};
    vecs[3]  = '{"lh",   7'b0001000, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 32'h0000_1002, 32'h8001_1234, 32'hFFFF_8001, 4'hF};
    vecs[4]  = '{"lhu",  7'b0000100, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 32'h0000_1000, 32'h8001_F234, 32'h0000_F234, 4'hF};
    vecs[5]  = '{"lw",   7'b1000000, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 32'h0000_1000, 32'h1234_5678, 32'h1234_5678, 4'hF};
    vecs[6]  = '{"lwl1", 7'b0000010, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 32'h0000_1001, 32'hAABB_CCDD, 32'hCCDD_0000, 4'b1100};
    vecs[7]  = '{"lwr2", 7'b0000001, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 32'h0000_1002, 32'hAABB_CCDD, 32'h0000_AABB, 4'b0011};
    vecs[8]  = '{"lwl0", 7'b0000010, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 32'h0000_1000, 32'hAABB_CCDD, 32'hDD00_0000, 4'b1000};
    vecs[9]  = '{"lwr3", 7'b0000001, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 32'h0000_1003, 32'hAABB_CCDD, 32'h0000_00AA, 4'b0001};
    vecs[10] = '{"exld", 7'b1000000, 1'b1, 1'b0, 1'b1, 5'h04, 4'hF, 32'h0000_1001, 32'h0, 32'h0, 4'b0000};
    vecs[11] = '{"sw",   7'b0000000, 1'b0, 1'b1, 1'b0, 5'd0, 4'h0, 32'h0000_0100, 32'h0, 32'h0000_0100, 4'h0};

    resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_allowin", ms_allowin, 1'b1);
    chk("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
    chk("rst_out_valid", out_ms_valid, 1'b0);
    chk("rst_ex_eret_mtc0_tlb", {ms_ex, ms_eret, ms_mtc0, ms_tlb_reflush}, 4'b0);
    chk("rst_load_wait", ms_load_wait, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      logic memop;
      memop = (vecs[i].rfm || vecs[i].st) && !vecs[i].ex;
      @(negedge clk);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = make_bus(vecs[i].ld, vecs[i].rfm, vecs[i].st, vecs[i].ex,
                                vecs[i].excode, vecs[i].gwe, vecs[i].res);
      ws_allowin = 1'b1;
      @(negedge clk);
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = vecs[i].rdata;
      data_sram_data_ok = 1'b0;
      #1;
      chk({vecs[i].nm, "_pre_valid"}, ms_to_ws_valid, !memop);
      chk({vecs[i].nm, "_load_wait"}, ms_load_wait, vecs[i].rfm && memop);
      if (memop) begin
        data_sram_data_ok = 1'b1;
        #1;
      end
      chk({vecs[i].nm, "_valid"}, ms_to_ws_valid, 1'b1);
      chk({vecs[i].nm, "_result"}, o_res, vecs[i].exp_res);
      chk({vecs[i].nm, "_fwd"}, ms_forward_data, vecs[i].exp_res);
      chk({vecs[i].nm, "_gr_we"}, o_gwe, vecs[i].exp_gwe);
      chk({vecs[i].nm, "_ms_ex"}, ms_ex, vecs[i].ex);
      chk({vecs[i].nm, "_excode"}, o_excode, vecs[i].excode);
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      #1;
      chk({vecs[i].nm, "_left"}, out_ms_valid, 1'b0);
    end

    // eret / mtc0 / tlbwi status forwarding
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = make_bus(7'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
    es_to_ms_bus[82] = 1'b1; es_to_ms_bus[81] = 1'b1; es_to_ms_bus[133] = 1'b1;
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1;
    chk("status_eret_mtc0_tlb", {ms_eret, ms_mtc0, ms_tlb_reflush}, 3'b111);

    // Buffered response while write-back stalls
    @(negedge clk);
    ws_allowin = 1'b0;
    issue_lw(32'h0000_0200);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5A5A_5A5A;
    #1;
    chk("buf_ready_stalled", ms_to_ws_valid, 1'b1);
    chk("buf_allowin_stalled", ms_allowin, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'h1111_1111 * (k + 1);
      #1;
      chk("buf_hold_valid", ms_to_ws_valid, 1'b1);
      chk("buf_hold_result", o_res, 32'h5A5A_5A5A);
    end
    @(negedge clk);
    ws_allowin = 1'b1;
    #1;
    chk("buf_release_result", o_res, 32'h5A5A_5A5A);
    chk("buf_release_allowin", ms_allowin, 1'b1);
    @(negedge clk);
    #1;
    chk("buf_left", out_ms_valid, 1'b0);
    issue_lw(32'h0000_0204);
    #1;
    chk("buf_cleared_wait", ms_to_ws_valid, 1'b0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_F00D;
    #1;
    chk("buf_cleared_result", o_res, 32'h0BAD_F00D);
    @(negedge clk);
    data_sram_data_ok = 1'b0;

    // Flush while a load waits: the stale response must be dropped
    issue_lw(32'h0000_0300);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_cleared_valid", out_ms_valid, 1'b0);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = make_bus(7'b1000000, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 32'h0000_0400);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_DEAD;
    #1;
    chk("discard_not_ready", ms_to_ws_valid, 1'b0);
    chk("discard_load_wait", ms_load_wait, 1'b1);
    @(negedge clk);
    data_sram_rdata = 32'h0000_BEEF;
    #1;
    chk("discard_second_valid", ms_to_ws_valid, 1'b1);
    chk("discard_second_result", o_res, 32'h0000_BEEF);
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1;
    chk("discard_left", out_ms_valid, 1'b0);

    // Flush and a new entry in the same cycle: flush wins
    es_to_ms_valid = 1'b1; flush = 1'b1;
    es_to_ms_bus = make_bus(7'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'hF, 32'h77);
    @(negedge clk);
    es_to_ms_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flush_beats_entry", out_ms_valid, 1'b0);

    // Async reset during a wait
    issue_lw(32'h0000_0500);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_wait_valid", out_ms_valid, 1'b0);
    chk("rst_mid_wait_allowin", ms_allowin, 1'b1);
    @(negedge clk);
    resetn = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
